// File: rtl/stream_parity_pkg.sv
// Shared types and helpers for the streaming frame-parity accumulator.
package stream_parity_pkg;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int unsigned SAT_W = 32;

  typedef struct packed {
    logic valid;
    logic wp;
    logic last;
    logic odd;
  } s1_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input logic [SAT_W-1:0] max_val);
    sat_inc = (cnt >= max_val) ? cnt : cnt + SAT_W'(1);
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational XOR reduction of one data word to a single parity bit.
module xor_reduce #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity_c
);

  assign parity_c = ^data;

endmodule

// File: rtl/stream_parity_accum.sv
// Per-frame parity and saturating beat count over a valid/ready word stream.
// Optional expected-parity check enabled by defining STREAM_PARITY_CHECK_EN.
module stream_parity_accum
  import stream_parity_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
`ifdef STREAM_PARITY_CHECK_EN
  input  logic             exp_parity,
  output logic             out_err,
  output logic             err_sticky,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic             wp_c;
  logic             proc_valid_c;
  logic             proc_wp_c;
  logic             proc_last_c;
  logic             proc_odd_c;
  logic             frame_par_c;
  logic [CNT_W-1:0] cnt_inc_c;

  logic             out_valid_q,  out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q,  out_count_d;
  logic             acc_q,        acc_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
`ifdef STREAM_PARITY_CHECK_EN
  logic             proc_exp_c;
  logic             out_err_q,    out_err_d;
  logic             err_sticky_q, err_sticky_d;
`endif

  xor_reduce #(.WIDTH(WIDTH)) u_xor_reduce (
    .data     (in_data),
    .parity_c (wp_c)
  );

  if (PIPE == 0) begin : g_comb
    assign in_ready     = !out_valid_q || out_ready;
    assign proc_valid_c = in_valid && in_ready;
    assign proc_wp_c    = wp_c;
    assign proc_last_c  = in_last;
    assign proc_odd_c   = odd_mode;
`ifdef STREAM_PARITY_CHECK_EN
    assign proc_exp_c   = exp_parity;
`endif
  end else begin : g_pipe
    s1_t  s1_q, s1_d;
    logic s1_drains_c;
`ifdef STREAM_PARITY_CHECK_EN
    logic s1_exp_q, s1_exp_d;
`endif

    // Only a completed frame can stall in s1, and only behind a held result.
    assign s1_drains_c  = !(s1_q.valid && s1_q.last && out_valid_q && !out_ready);
    assign in_ready     = !s1_q.valid || s1_drains_c;
    assign proc_valid_c = s1_q.valid && s1_drains_c;
    assign proc_wp_c    = s1_q.wp;
    assign proc_last_c  = s1_q.last;
    assign proc_odd_c   = s1_q.odd;

    // Unaccepted beats load zeros so idle data never reaches the accumulator.
    always_comb begin
      s1_d = s1_q;
      if (in_ready) begin
        s1_d.valid = in_valid;
        s1_d.wp    = in_valid & wp_c;
        s1_d.last  = in_valid & in_last;
        s1_d.odd   = in_valid & odd_mode;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_q <= '0;
      else        s1_q <= s1_d;
    end

`ifdef STREAM_PARITY_CHECK_EN
    assign proc_exp_c = s1_exp_q;

    always_comb begin
      s1_exp_d = s1_exp_q;
      if (in_ready) s1_exp_d = in_valid & exp_parity;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_exp_q <= 1'b0;
      else        s1_exp_q <= s1_exp_d;
    end
`endif
  end

  assign cnt_inc_c   = CNT_W'(sat_inc(SAT_W'(cnt_q), CNT_MAX));
  assign frame_par_c = acc_q ^ proc_wp_c ^ (proc_odd_c == ODD);

  // Accumulate at the processing point; a last beat loads the output register.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
`ifdef STREAM_PARITY_CHECK_EN
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q | (out_valid_q & out_ready & out_err_q);
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (proc_valid_c) begin
      if (proc_last_c) begin
        out_valid_d  = 1'b1;
        out_parity_d = frame_par_c;
        out_count_d  = cnt_inc_c;
        acc_d        = 1'b0;
        cnt_d        = '0;
`ifdef STREAM_PARITY_CHECK_EN
        out_err_d    = frame_par_c ^ proc_exp_c;
`endif
      end else begin
        acc_d = acc_q ^ proc_wp_c;
        cnt_d = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef STREAM_PARITY_CHECK_EN
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
`ifdef STREAM_PARITY_CHECK_EN
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
`ifdef STREAM_PARITY_CHECK_EN
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_stream_parity_accum.sv
// Directed bench for stream_parity_accum: PIPE=0 (dut 0), PIPE=1 (dut 1), CNT_W=2 (dut 2).
module tb_stream_parity_accum;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid [3];
  logic       in_last  [3];
  logic       odd_mode [3];
  logic       out_ready[3];
  logic [3:0] in_data  [3];
  logic       in_ready [3];
  logic       out_valid[3];
  logic       out_parity[3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
`ifdef STREAM_PARITY_CHECK_EN
  logic       exp_parity[3];
  logic       out_err   [3];
  logic       err_sticky[3];
`endif
  logic       last_exp;

  typedef struct {
    logic       par;
    logic [7:0] cnt;
    logic       err;
    int         cyc;
  } rec_t;

  rec_t q0[$], q1[$], q2[$];
  int tests = 0;
  int fails = 0;

  stream_parity_accum #(.WIDTH(4), .CNT_W(8), .PIPE(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .odd_mode(odd_mode[0]),
`ifdef STREAM_PARITY_CHECK_EN
    .exp_parity(exp_parity[0]), .out_err(out_err[0]), .err_sticky(err_sticky[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_parity(out_parity[0]),
    .out_count(cnt0));

  stream_parity_accum #(.WIDTH(4), .CNT_W(8), .PIPE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .odd_mode(odd_mode[1]),
`ifdef STREAM_PARITY_CHECK_EN
    .exp_parity(exp_parity[1]), .out_err(out_err[1]), .err_sticky(err_sticky[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_parity(out_parity[1]),
    .out_count(cnt1));

  stream_parity_accum #(.WIDTH(4), .CNT_W(2), .PIPE(0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_last(in_last[2]), .odd_mode(odd_mode[2]),
`ifdef STREAM_PARITY_CHECK_EN
    .exp_parity(exp_parity[2]), .out_err(out_err[2]), .err_sticky(err_sticky[2]),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_parity(out_parity[2]),
    .out_count(cnt2));

  function automatic rec_t mk_rec(input logic p, input logic [7:0] c, input logic e, input int cy);
    rec_t r;
    r.par = p; r.cnt = c; r.err = e; r.cyc = cy;
    return r;
  endfunction

  // Record every output handshake with the cycle it was presented in.
  always @(negedge clk) begin
    #2;
`ifdef STREAM_PARITY_CHECK_EN
    if (out_valid[0] && out_ready[0]) q0.push_back(mk_rec(out_parity[0], cnt0, out_err[0], cyc));
    if (out_valid[1] && out_ready[1]) q1.push_back(mk_rec(out_parity[1], cnt1, out_err[1], cyc));
    if (out_valid[2] && out_ready[2]) q2.push_back(mk_rec(out_parity[2], 8'(cnt2), out_err[2], cyc));
`else
    if (out_valid[0] && out_ready[0]) q0.push_back(mk_rec(out_parity[0], cnt0, 1'b0, cyc));
    if (out_valid[1] && out_ready[1]) q1.push_back(mk_rec(out_parity[1], cnt1, 1'b0, cyc));
    if (out_valid[2] && out_ready[2]) q2.push_back(mk_rec(out_parity[2], 8'(cnt2), 1'b0, cyc));
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Present one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input int d, input logic [3:0] data, input logic last,
                           input logic odd, input logic exp, output int acc_cyc);
    bit done = 0;
    acc_cyc = -1;
    in_valid[d] = 1'b1; in_data[d] = data; in_last[d] = last; odd_mode[d] = odd;
    last_exp = exp;
`ifdef STREAM_PARITY_CHECK_EN
    exp_parity[d] = exp;
`endif
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (in_ready[d]) begin done = 1; acc_cyc = cyc; end
      @(negedge clk);
    end
    in_valid[d] = 1'b0; in_data[d] = 4'h0; in_last[d] = 1'b0; odd_mode[d] = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout dut%0d data=%h got no accept, required accept within 100 cycles", d, data);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_last[d] = 1'b0; odd_mode[d] = 1'b0; in_data[d] = 4'h0;
      out_ready[d] = 1'b1;
`ifdef STREAM_PARITY_CHECK_EN
      exp_parity[d] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++; if (out_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_out_valid dut%0d got %b required 0", d, out_valid[d]); end
      tests++; if (out_parity[d] !== 1'b0) begin fails++; $display("FAIL reset_out_parity dut%0d got %b required 0", d, out_parity[d]); end
      tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL reset_in_ready dut%0d got %b required 1", d, in_ready[d]); end
`ifdef STREAM_PARITY_CHECK_EN
      tests++; if (out_err[d] !== 1'b0 || err_sticky[d] !== 1'b0) begin fails++; $display("FAIL reset_err dut%0d got %b%b required 00", d, out_err[d], err_sticky[d]); end
`endif
    end
    tests++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || cnt2 !== 2'd0) begin fails++; $display("FAIL reset_out_count got %0d/%0d/%0d required 0/0/0", cnt0, cnt1, cnt2); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int a;
    q0.delete();
    send_beat(0, 4'b1011, 1'b1, 1'b0, 1'b0, a);
    repeat (2) @(negedge clk);
    tests++; if (q0.size() != 1) begin fails++; $display("FAIL single_results got %0d required 1", q0.size()); end
    else begin
      tests++; if (q0[0].par !== 1'b1) begin fails++; $display("FAIL single_parity got %b required 1", q0[0].par); end
      tests++; if (q0[0].cnt !== 8'd1) begin fails++; $display("FAIL single_count got %0d required 1", q0[0].cnt); end
      tests++; if (q0[0].cyc - a != 1) begin fails++; $display("FAIL single_latency got %0d required 1", q0[0].cyc - a); end
    end
  endtask

  task automatic test_multi_beat();
    int a;
    for (int d = 0; d < 2; d++) begin
      q0.delete(); q1.delete();
      send_beat(d, 4'hF, 1'b0, 1'b0, 1'b0, a);
      send_beat(d, 4'h1, 1'b0, 1'b0, 1'b0, a);
      send_beat(d, 4'h3, 1'b1, 1'b1, 1'b1, a);
      repeat (3) @(negedge clk);
      if (d == 0) begin
        tests++; if (q0.size() != 1) begin fails++; $display("FAIL multi_results dut0 got %0d required 1", q0.size()); end
        else begin
          tests++; if (q0[0].par !== 1'b0 || q0[0].cnt !== 8'd3) begin fails++; $display("FAIL multi_frame dut0 got par=%b cnt=%0d required par=0 cnt=3", q0[0].par, q0[0].cnt); end
          tests++; if (q0[0].cyc - a != 1) begin fails++; $display("FAIL multi_latency dut0 got %0d required 1", q0[0].cyc - a); end
        end
      end else begin
        tests++; if (q1.size() != 1) begin fails++; $display("FAIL multi_results dut1 got %0d required 1", q1.size()); end
        else begin
          tests++; if (q1[0].par !== 1'b0 || q1[0].cnt !== 8'd3) begin fails++; $display("FAIL multi_frame dut1 got par=%b cnt=%0d required par=0 cnt=3", q1[0].par, q1[0].cnt); end
          tests++; if (q1[0].cyc - a != 2) begin fails++; $display("FAIL multi_latency dut1 got %0d required 2", q1[0].cyc - a); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int a;
    logic [7:0] exp_cnt [3];
    logic       exp_par [3];
    exp_cnt[0] = 8'd1; exp_par[0] = 1'b0;
    exp_cnt[1] = 8'd2; exp_par[1] = 1'b1;
    exp_cnt[2] = 8'd1; exp_par[2] = 1'b1;
    q0.delete();
    out_ready[0] = 1'b0;
    send_beat(0, 4'h5, 1'b1, 1'b0, 1'b0, a);
    fork
      begin
        int b;
        send_beat(0, 4'h3, 1'b0, 1'b0, 1'b0, b);
        send_beat(0, 4'h7, 1'b1, 1'b0, 1'b0, b);
        send_beat(0, 4'h6, 1'b1, 1'b1, 1'b0, b);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          #1;
          tests++; if (out_valid[0] !== 1'b1 || out_parity[0] !== 1'b0 || cnt0 !== 8'd1) begin fails++; $display("FAIL hold_result cyc%0d got v=%b par=%b cnt=%0d required v=1 par=0 cnt=1", i, out_valid[0], out_parity[0], cnt0); end
          tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL hold_in_ready cyc%0d got %b required 0", i, in_ready[0]); end
          @(negedge clk);
        end
        out_ready[0] = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    tests++; if (q0.size() != 3) begin fails++; $display("FAIL bp_results got %0d required 3", q0.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (q0[i].par !== exp_par[i] || q0[i].cnt !== exp_cnt[i]) begin fails++; $display("FAIL bp_order res%0d got par=%b cnt=%0d required par=%b cnt=%0d", i, q0[i].par, q0[i].cnt, exp_par[i], exp_cnt[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, first;
    logic [7:0] par_tbl;
    par_tbl = 8'b1001_0110;
    q1.delete();
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(1, 4'(i), 1'b1, 1'b0, 1'b0, a);
      if (i == 0) first = a;
    end
    repeat (4) @(negedge clk);
    tests++; if (q1.size() != 8) begin fails++; $display("FAIL b2b_results got %0d required 8", q1.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        tests++; if (q1[i].par !== par_tbl[i] || q1[i].cnt !== 8'd1) begin fails++; $display("FAIL b2b_frame res%0d got par=%b cnt=%0d required par=%b cnt=1", i, q1[i].par, q1[i].cnt, par_tbl[i]); end
        tests++; if (q1[i].cyc != first + 2 + i) begin fails++; $display("FAIL b2b_timing res%0d got cycle %0d required %0d", i, q1[i].cyc, first + 2 + i); end
      end
    end
  endtask

  task automatic test_saturation();
    int a;
    q2.delete();
    for (int i = 0; i < 6; i++) send_beat(2, 4'h1, (i == 5), 1'b0, 1'b0, a);
    for (int i = 0; i < 5; i++) send_beat(2, 4'h1, (i == 4), 1'b0, 1'b0, a);
    repeat (2) @(negedge clk);
    tests++; if (q2.size() != 2) begin fails++; $display("FAIL sat_results got %0d required 2", q2.size()); end
    else begin
      tests++; if (q2[0].par !== 1'b0 || q2[0].cnt !== 8'd3) begin fails++; $display("FAIL sat_six got par=%b cnt=%0d required par=0 cnt=3", q2[0].par, q2[0].cnt); end
      tests++; if (q2[1].par !== 1'b1 || q2[1].cnt !== 8'd3) begin fails++; $display("FAIL sat_five got par=%b cnt=%0d required par=1 cnt=3", q2[1].par, q2[1].cnt); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int a;
    out_ready[2] = 1'b0;
    send_beat(2, 4'h1, 1'b1, 1'b0, 1'b0, a);
    send_beat(0, 4'h1, 1'b0, 1'b0, 1'b0, a);
    send_beat(0, 4'h3, 1'b0, 1'b0, 1'b0, a);
    send_beat(1, 4'h1, 1'b0, 1'b0, 1'b0, a);
    send_beat(1, 4'h3, 1'b0, 1'b0, 1'b0, a);
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin fails++; $display("FAIL rst_pending got v=%b rdy=%b required v=0 rdy=1", out_valid[2], in_ready[2]); end
`ifdef STREAM_PARITY_CHECK_EN
    tests++; if (err_sticky[0] !== 1'b0) begin fails++; $display("FAIL rst_sticky got %b required 0", err_sticky[0]); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[2] = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++; if (out_valid[d] !== 1'b0) begin fails++; $display("FAIL rst_idle dut%0d got %b required 0", d, out_valid[d]); end
    end
    send_beat(0, 4'h7, 1'b1, 1'b0, 1'b0, a);
    send_beat(1, 4'h7, 1'b1, 1'b0, 1'b0, a);
    repeat (3) @(negedge clk);
    tests++; if (q2.size() != 0) begin fails++; $display("FAIL rst_discard got %0d results required 0", q2.size()); end
    tests++; if (q0.size() != 1) begin fails++; $display("FAIL rst_new_results dut0 got %0d required 1", q0.size()); end
    else begin
      tests++; if (q0[0].par !== 1'b1 || q0[0].cnt !== 8'd1) begin fails++; $display("FAIL rst_new_frame dut0 got par=%b cnt=%0d required par=1 cnt=1", q0[0].par, q0[0].cnt); end
`ifdef STREAM_PARITY_CHECK_EN
      tests++; if (q0[0].err !== 1'b1) begin fails++; $display("FAIL rst_out_err got %b required 1", q0[0].err); end
      tests++; if (err_sticky[0] !== 1'b1) begin fails++; $display("FAIL rst_err_sticky got %b required 1", err_sticky[0]); end
`endif
    end
    tests++; if (q1.size() != 1) begin fails++; $display("FAIL rst_new_results dut1 got %0d required 1", q1.size()); end
    else begin
      tests++; if (q1[0].par !== 1'b1 || q1[0].cnt !== 8'd1) begin fails++; $display("FAIL rst_new_frame dut1 got par=%b cnt=%0d required par=1 cnt=1", q1[0].par, q1[0].cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
